// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer time-sharing one ripple-carry ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  input  logic [3:0]        req0_ctrl,
  input  logic [3:0]        req1_ctrl,
  input  logic [2:0]        req0_bonus,
  input  logic [2:0]        req1_bonus,
  output logic              alu_rst_n,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [3:0]        alu_ctrl,
  output logic [2:0]        alu_bonus,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_cout,
  output logic              rsp_overflow,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t     state;
  logic       rr;
  logic       id_q;
  logic [3:0] cnt;
  logic       idle;
  assign idle       = state == IDLE && !rst_i;
  assign req0_ready = idle && req0_valid && (!req1_valid || !rr);
  assign req1_ready = idle && req1_valid && (!req0_valid || rr);
  assign busy       = state != IDLE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state        <= IDLE;
      rr           <= 1'b0;
      id_q         <= 1'b0;
      cnt          <= '0;
      alu_rst_n    <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= '0;
      alu_bonus    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      alu_rst_n <= 1'b1;
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          alu_src1  <= req1_ready ? req1_src1 : req0_src1;
          alu_src2  <= req1_ready ? req1_src2 : req0_src2;
          alu_ctrl  <= req1_ready ? req1_ctrl : req0_ctrl;
          alu_bonus <= req1_ready ? req1_bonus : req0_bonus;
          id_q      <= req1_ready;
          cnt       <= CNT_INIT;
          state     <= EXEC;
        end
        // operands stay frozen while the ripple chain settles
        EXEC: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_cout     <= alu_cout;
          rsp_overflow <= alu_overflow;
          rsp_id       <= id_q;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rr        <= ~rsp_id;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of grant order, settle timing, backpressure and abort
module tb_alu_share_arbiter;
  localparam int W = 32;
  logic clk_i = 1'b0;
  logic rst_i;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0] req0_ctrl, req1_ctrl;
  logic [2:0] req0_bonus, req1_bonus;
  logic alu_rst_n;
  logic [W-1:0] alu_src1, alu_src2, alu_result;
  logic [3:0] alu_ctrl;
  logic [2:0] alu_bonus;
  logic alu_zero, alu_cout, alu_overflow;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_cout, rsp_overflow, busy;
  logic [W-1:0] rsp_result;
  logic [W:0] sum;
  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.DATA_W(W), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_bonus(req0_bonus), .req1_bonus(req1_bonus),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  // behavioural stand-in for the shared ALU
  always_comb begin
    sum          = '0;
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b0010: begin
        sum          = {1'b0, alu_src1} + {1'b0, alu_src2};
        alu_result   = sum[W-1:0];
        alu_cout     = sum[W];
        alu_overflow = (alu_src1[W-1] == alu_src2[W-1]) && (alu_result[W-1] != alu_src1[W-1]);
      end
      4'b0110: begin
        sum          = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        alu_result   = sum[W-1:0];
        alu_cout     = sum[W];
        alu_overflow = (alu_src1[W-1] != alu_src2[W-1]) && (alu_result[W-1] != alu_src1[W-1]);
      end
      4'b0111: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      4'b1100: alu_result = ~(alu_src1 | alu_src2);
      default: alu_result = '0;
    endcase
    if (!alu_rst_n) begin
      alu_result   = '0;
      alu_cout     = 1'b0;
      alu_overflow = 1'b0;
    end
    alu_zero = alu_result == '0;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    int n = 0;
    if (id) begin
      req1_src1 = a; req1_src2 = b; req1_ctrl = c; req1_bonus = 3'd0; req1_valid = 1'b1;
    end else begin
      req0_src1 = a; req0_src2 = b; req0_ctrl = c; req0_bonus = 3'd0; req0_valid = 1'b1;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick; n++; end
    chk("grant_wait", id ? req1_ready : req0_ready, 1);
    tick;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin tick; n++; end
    chk(tag, rsp_valid, 1);
  endtask

  logic [W-1:0] a0 [3] = '{32'd1, 32'hFFFFFFFF, 32'd0};
  logic [W-1:0] b0 [3] = '{32'd2, 32'd1, 32'd0};
  logic [3:0]   c0 [3] = '{4'b0010, 4'b0111, 4'b1100};
  logic [W-1:0] r0 [3] = '{32'd3, 32'd1, 32'hFFFFFFFF};
  logic [W-1:0] a1 [3] = '{32'hA0, 32'd10, 32'hFF};
  logic [W-1:0] b1 [3] = '{32'h0B, 32'd3, 32'h3C};
  logic [3:0]   c1 [3] = '{4'b0001, 4'b0110, 4'b0000};
  logic [W-1:0] r1 [3] = '{32'hAB, 32'd7, 32'h3C};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int i0, i1, n;
    rst_i = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0; req0_bonus = '0;
    req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0; req1_bonus = '0;
    // async reset between edges
    #2 rst_i = 1'b1;
    #1;
    chk("rst_alu_rst_n", alu_rst_n, 0);
    chk("rst_alu_src1", alu_src1, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    tick; tick;
    rst_i = 1'b0;
    #1 chk("rel_alu_rst_n_pre", alu_rst_n, 0);
    tick;
    chk("rel_alu_rst_n", alu_rst_n, 1);
    chk("rel_busy", busy, 0);

    // single add, exact latency
    rsp_ready = 1'b1;
    req0_src1 = 32'd5; req0_src2 = 32'd7; req0_ctrl = 4'b0010; req0_bonus = 3'b101; req0_valid = 1'b1;
    #1;
    chk("add_ready0", req0_ready, 1);
    chk("add_ready1", req1_ready, 0);
    tick;
    req0_valid = 1'b0;
    #1;
    chk("add_busy", busy, 1);
    chk("add_ready0_off", req0_ready, 0);
    chk("add_alu_src1", alu_src1, 5);
    chk("add_alu_src2", alu_src2, 7);
    chk("add_alu_ctrl", alu_ctrl, 4'b0010);
    chk("add_alu_bonus", alu_bonus, 3'b101);
    tick;
    chk("add_rsp_early", rsp_valid, 0);
    tick;
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_id", rsp_id, 0);
    chk("add_result", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_cout", rsp_cout, 0);
    chk("add_ovf", rsp_overflow, 0);
    tick;
    chk("add_accept_valid", rsp_valid, 0);
    chk("add_accept_busy", busy, 0);

    // sub overflow and zero result from requester 1
    issue(1, 32'h80000000, 32'd1, 4'b0110);
    wait_rsp("subovf_rsp");
    chk("subovf_id", rsp_id, 1);
    chk("subovf_result", rsp_result, 32'h7FFFFFFF);
    chk("subovf_ovf", rsp_overflow, 1);
    chk("subovf_cout", rsp_cout, 1);
    chk("subovf_zero", rsp_zero, 0);
    tick;
    issue(1, 32'd9, 32'd9, 4'b0110);
    wait_rsp("subz_rsp");
    chk("subz_result", rsp_result, 0);
    chk("subz_zero", rsp_zero, 1);
    chk("subz_ovf", rsp_overflow, 0);
    tick;

    // backpressure; rr now points at requester 0
    rsp_ready = 1'b0;
    issue(0, 32'hFFFF0000, 32'h00FFFF00, 4'b0000);
    req0_src1 = 32'd1; req0_src2 = 32'd1; req0_ctrl = 4'b0010; req0_valid = 1'b1;
    req1_src1 = 32'd2; req1_src2 = 32'd2; req1_ctrl = 4'b0010; req1_valid = 1'b1;
    wait_rsp("bp_rsp");
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'h00FF0000);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick;
    chk("bp_rel_valid", rsp_valid, 0);
    chk("bp_rel_busy", busy, 0);
    chk("bp_rel_ready1", req1_ready, 1);
    chk("bp_rel_ready0", req0_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // contention after a fresh reset: grants 0,1,0,1,0,1
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    tick;
    i0 = 0; i1 = 0;
    req0_src1 = a0[0]; req0_src2 = b0[0]; req0_ctrl = c0[0]; req0_valid = 1'b1;
    req1_src1 = a1[0]; req1_src2 = b1[0]; req1_ctrl = c1[0]; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin tick; n++; end
      chk("cont_grant_seen", req0_ready | req1_ready, 1);
      chk("cont_grant_id", req1_ready, k % 2);
      chk("cont_onehot", req0_ready & req1_ready, 0);
      tick;
      if (k % 2 == 0) begin
        i0++;
        if (i0 < 3) begin req0_src1 = a0[i0]; req0_src2 = b0[i0]; req0_ctrl = c0[i0]; end
        else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 3) begin req1_src1 = a1[i1]; req1_src2 = b1[i1]; req1_ctrl = c1[i1]; end
        else req1_valid = 1'b0;
      end
      wait_rsp("cont_rsp");
      chk("cont_rsp_id", rsp_id, k % 2);
      chk("cont_result", rsp_result, (k % 2) ? r1[k/2] : r0[k/2]);
      tick;
    end

    // abort mid-EXEC
    issue(0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000);
    chk("abort_busy", busy, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_busy_clr", busy, 0);
    chk("abort_alu_rst_n", alu_rst_n, 0);
    chk("abort_alu_src1", alu_src1, 0);
    tick; tick; tick;
    chk("abort_no_rsp", rsp_valid, 0);
    rst_i = 1'b0;
    tick;
    chk("abort_alu_rst_n_rel", alu_rst_n, 1);
    chk("abort_no_rsp_rel", rsp_valid, 0);
    issue(0, 32'hF0, 32'h0F, 4'b0001);
    wait_rsp("abort_or_rsp");
    chk("abort_or_id", rsp_id, 0);
    chk("abort_or_result", rsp_result, 32'hFF);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
